// File: rtl/unified_mem.sv
// rtl/unified_mem.sv - unified instruction/data memory with boot clear/load sequencer
module unified_mem #(
    parameter int ADDR_W    = 9,
    parameter bit INIT_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    output logic [31:0]       i,
    output logic              i_misalign,
    input  logic [31:0]       d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic              we,
    input  logic [31:0]       di,
    output logic [31:0]       dout,
    output logic              d_misalign,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ready
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] i_idx;
    logic [ADDR_W-1:0] d_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       d_word;
    logic [31:0]       wr_data;
    logic [3:0]        wr_mask;
    logic [7:0]        d_byte;
    logic [15:0]       d_half;

    assign i_idx      = i_addr[ADDR_W+1:2];
    assign d_idx      = d_addr[ADDR_W+1:2];
    assign i          = mem[i_idx];
    assign i_misalign = |i_addr[1:0];
    assign d_word     = mem[d_idx];
    assign d_byte     = d_word[{d_addr[1:0], 3'b000} +: 8];
    assign d_half     = d_addr[1] ? d_word[31:16] : d_word[15:0];

    always_comb begin
        d_misalign = 1'b0;
        case (d_size)
            2'b00:   d_misalign = 1'b0;
            2'b01:   d_misalign = d_addr[0];
            2'b10:   d_misalign = |d_addr[1:0];
            default: d_misalign = 1'b1;
        endcase
    end

    always_comb begin
        dout = 32'h0;
        if (!d_misalign) begin
            case (d_size)
                2'b00:   dout = d_unsigned ? {24'h0, d_byte} : {{24{d_byte[7]}}, d_byte};
                2'b01:   dout = d_unsigned ? {16'h0, d_half} : {{16{d_half[15]}}, d_half};
                default: dout = d_word;
            endcase
        end
    end

    // Single write port shared by the sweep, the image loader and CPU stores.
    // Writes are gated by rst so an edge during reset never touches the array.
    always_comb begin
        wr_idx  = cnt;
        wr_data = 32'h0;
        wr_mask = 4'b0000;
        case (state)
            CLEAR: wr_mask = {4{rst}};
            LOAD: begin
                wr_idx  = ld_addr;
                wr_data = ld_data;
                wr_mask = {4{ld_valid & rst}};
            end
            default: begin
                wr_idx = d_idx;
                if (we && !d_misalign && rst) begin
                    case (d_size)
                        2'b00: begin
                            wr_data = {4{di[7:0]}};
                            wr_mask = 4'b0001 << d_addr[1:0];
                        end
                        2'b01: begin
                            wr_data = {2{di[15:0]}};
                            wr_mask = d_addr[1] ? 4'b1100 : 4'b0011;
                        end
                        default: begin
                            wr_data = di;
                            wr_mask = 4'b1111;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            ready    <= 1'b0;
            ld_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (&cnt) begin
                        if (INIT_LOAD) begin
                            state    <= LOAD;
                            ld_ready <= 1'b1;
                        end else begin
                            state <= RUN;
                            ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (ld_valid && ld_last) begin
                        state    <= RUN;
                        ld_ready <= 1'b0;
                        ready    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem.sv
// tb/tb_unified_mem.sv - randomized self-checking bench for unified_mem against a byte-array model
module tb_unified_mem;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NB    = DEPTH * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rst2;
    logic [31:0]   i_addr, d_addr, di, ld_data;
    logic [1:0]    d_size;
    logic          d_unsigned, we, ld_valid, ld_last;
    logic [AW-1:0] ld_addr;
    logic [31:0]   i_w, dout_w, i2_w, dout2_w;
    logic          i_mis, d_mis, i2_mis, d2_mis;
    logic          ld_ready, ready, ld_ready2, ready2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mb [NB];

    unified_mem #(.ADDR_W(AW), .INIT_LOAD(1'b1)) u_dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i(i_w), .i_misalign(i_mis),
        .d_addr(d_addr), .d_size(d_size), .d_unsigned(d_unsigned), .we(we), .di(di),
        .dout(dout_w), .d_misalign(d_mis), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .ready(ready)
    );

    unified_mem #(.ADDR_W(AW), .INIT_LOAD(1'b0)) u_dut_noload (
        .clk(clk), .rst(rst2), .i_addr(i_addr), .i(i2_w), .i_misalign(i2_mis),
        .d_addr(d_addr), .d_size(d_size), .d_unsigned(d_unsigned), .we(1'b0), .di(di),
        .dout(dout2_w), .d_misalign(d2_mis), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready2), .ready(ready2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input int w);
        int a;
        a = (w % DEPTH) * 4;
        return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    endfunction

    function automatic bit m_mis(input logic [31:0] addr, input logic [1:0] sz);
        int nbytes;
        nbytes = 1 << sz;
        return (sz == 2'b11) || ((int'(addr[1:0]) % nbytes) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
        int a;
        int s;
        a = int'(addr[AW+1:0]);
        if (m_mis(addr, sz)) return 32'h0;
        if (sz == 2'b10) return m_word(a / 4);
        if (sz == 2'b00) begin
            s = int'(mb[a]);
            if (!uns && s >= 128) s -= 256;
        end else begin
            s = int'(mb[a]) + 256 * int'(mb[a+1]);
            if (!uns && s >= 32768) s -= 65536;
        end
        return 32'(s);
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
        int a;
        a = int'(addr[AW+1:0]);
        if (m_mis(addr, sz)) return;
        for (int k = 0; k < (1 << sz); k++) mb[a+k] = data[8*k +: 8];
    endtask

    task automatic m_clear();
        for (int k = 0; k < NB; k++) mb[k] = 8'h00;
    endtask

    task automatic count_edges(output int n_ld, output int n_run);
        n_ld  = 0;
        n_run = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ld_ready && n_ld == 0) n_ld = k;
            if (ready2 && n_run == 0) n_run = k;
        end
    endtask

    task automatic load_beat(input logic [AW-1:0] a, input logic [31:0] data, input logic last, input logic valid);
        @(negedge clk);
        ld_addr  = a;
        ld_data  = data;
        ld_last  = last;
        ld_valid = valid;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic peek_i(input logic [31:0] a);
        @(negedge clk);
        i_addr = a;
        #1;
    endtask

    task automatic cpu_op(input string tag, input logic [31:0] ia, input logic [31:0] a,
                          input logic [1:0] sz, input logic uns, input logic w, input logic [31:0] data);
        @(negedge clk);
        i_addr = ia; d_addr = a; d_size = sz; d_unsigned = uns; we = w; di = data;
        #1;
        check({tag, " do"}, dout_w, m_load(a, sz, uns));
        check({tag, " d_misalign"}, 32'(d_mis), 32'(m_mis(a, sz)));
        check({tag, " i"}, i_w, m_word(int'(ia[AW+1:2])));
        check({tag, " i_misalign"}, 32'(i_mis), 32'((ia % 4) != 0));
        @(posedge clk);
        if (w) m_store(a, sz, data);
        #1;
        if (w) begin
            check({tag, " do after edge"}, dout_w, m_load(a, sz, uns));
            check({tag, " i after edge"}, i_w, m_word(int'(ia[AW+1:2])));
        end
        we = 1'b0;
    endtask

    initial begin
        int n_ld, n_run;
        rst = 1'b0; rst2 = 1'b0;
        i_addr = '0; d_addr = '0; di = '0; d_size = 2'b10; d_unsigned = 1'b0; we = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
        m_clear();
        repeat (2) @(negedge clk);
        #1;
        check("reset ready", 32'(ready), 32'h0);
        check("reset ld_ready", 32'(ld_ready), 32'h0);
        check("reset ready noload", 32'(ready2), 32'h0);

        @(negedge clk);
        rst = 1'b1; rst2 = 1'b1;
        count_edges(n_ld, n_run);
        check("boot edges ld_ready", 32'(n_ld), 32'd16);
        check("boot edges ready noload", 32'(n_run), 32'd16);
        check("noload ld_ready", 32'(ld_ready2), 32'h0);
        peek_i(32'h8);
        check("noload cleared", i2_w, 32'h0);

        for (int w = 0; w < DEPTH; w++) load_beat(AW'(w), 32'hFFFF_FFFF, w == DEPTH - 1, 1'b1);
        check("preload ready", 32'(ready), 32'h1);
        check("preload ld_ready", 32'(ld_ready), 32'h0);
        peek_i(32'h1C);
        check("preload word7", i_w, 32'hFFFF_FFFF);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready drops in reset", 32'(ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        count_edges(n_ld, n_run);
        check("reclear edges", 32'(n_ld), 32'd16);
        m_clear();
        for (int w = 0; w < DEPTH; w++) begin
            peek_i(32'(w * 4));
            check("cleared word", i_w, 32'h0);
        end

        load_beat(AW'(3), 32'h1, 1'b1, 1'b0);
        check("last without valid ld_ready", 32'(ld_ready), 32'h1);
        check("last without valid ready", 32'(ready), 32'h0);

        load_beat(AW'(5), 32'h1234_5678, 1'b0, 1'b1);
        peek_i(32'h14);
        check("loaded word5", i_w, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort load ld_ready", 32'(ld_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        count_edges(n_ld, n_run);
        check("mid-clear restart edges", 32'(n_ld), 32'd16);
        peek_i(32'h14);
        check("aborted word5 zeroed", i_w, 32'h0);

        load_beat(AW'(0), 32'h0050_0093, 1'b0, 1'b1);
        load_beat(AW'(1), 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("ready after last beat", 32'(ready), 32'h1);
        m_store(32'h0, 2'b10, 32'h0050_0093);
        m_store(32'h4, 2'b10, 32'hDEAD_BEEF);
        peek_i(32'h4);
        check("i at 4", i_w, 32'hDEAD_BEEF);
        load_beat(AW'(2), 32'hAAAA_AAAA, 1'b1, 1'b1);
        peek_i(32'h8);
        check("load port ignored in run", i_w, 32'h0);

        cpu_op("sw w3", 32'h0C, 32'h0C, 2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF);
        cpu_op("sb", 32'h0C, 32'h0D, 2'b00, 1'b0, 1'b1, 32'h0000_005A);
        check("word3 after sb", i_w, 32'hDEAD_5AEF);
        cpu_op("sh", 32'h0C, 32'h0E, 2'b01, 1'b0, 1'b1, 32'h0000_1234);
        check("word3 after sh", i_w, 32'h1234_5AEF);
        cpu_op("lb", 32'h0C, 32'h0D, 2'b00, 1'b0, 1'b0, 32'h0);
        check("lb 0x0D", dout_w, 32'h0000_005A);
        cpu_op("lh", 32'h0C, 32'h0E, 2'b01, 1'b0, 1'b0, 32'h0);
        check("lh 0x0E", dout_w, 32'h0000_1234);

        cpu_op("sw w4", 32'h10, 32'h10, 2'b10, 1'b0, 1'b1, 32'h80FF_7F01);
        cpu_op("lb +1", 32'h10, 32'h11, 2'b00, 1'b0, 1'b0, 32'h0);
        check("lb +1", dout_w, 32'h0000_007F);
        cpu_op("lb +2", 32'h10, 32'h12, 2'b00, 1'b0, 1'b0, 32'h0);
        check("lb +2", dout_w, 32'hFFFF_FFFF);
        cpu_op("lbu +2", 32'h10, 32'h12, 2'b00, 1'b1, 1'b0, 32'h0);
        check("lbu +2", dout_w, 32'h0000_00FF);
        cpu_op("lh +2", 32'h10, 32'h12, 2'b01, 1'b0, 1'b0, 32'h0);
        check("lh +2", dout_w, 32'hFFFF_80FF);
        cpu_op("lhu +2", 32'h10, 32'h12, 2'b01, 1'b1, 1'b0, 32'h0);
        check("lhu +2", dout_w, 32'h0000_80FF);

        cpu_op("sw mis", 32'h10, 32'h11, 2'b10, 1'b0, 1'b1, 32'h5555_5555);
        check("sw mis flag", 32'(d_mis), 32'h1);
        check("sw mis do", dout_w, 32'h0);
        check("sw mis unchanged", i_w, 32'h80FF_7F01);
        cpu_op("lh mis", 32'h10, 32'h13, 2'b01, 1'b0, 1'b0, 32'h0);
        check("lh mis flag", 32'(d_mis), 32'h1);
        cpu_op("size11", 32'h10, 32'h10, 2'b11, 1'b0, 1'b1, 32'h7777_7777);
        check("size11 flag", 32'(d_mis), 32'h1);
        check("size11 unchanged", i_w, 32'h80FF_7F01);
        cpu_op("i mis", 32'h06, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
        check("i mis flag", 32'(i_mis), 32'h1);
        check("i mis word", i_w, 32'hDEAD_BEEF);

        cpu_op("same addr", 32'h20, 32'h20, 2'b10, 1'b0, 1'b1, 32'hCAFE_F00D);
        check("same addr new", dout_w, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            cpu_op("rand", $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
